spi_burst_rom: RTL and testbench

SPI_BURST_ROM -- requirements
Module: spi_burst_rom

---
 rtl/spi_rom_pkg.sv | 25 ++
 rtl/spi_rom_core.sv | 15 +
 rtl/spi_burst_rom.sv | 108 ++++++++++
 tb/tb_spi_burst_rom.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rom_pkg.sv
// Shared types and the ROM content rule for the SPI burst ROM.
// word() works on a 64-bit sum, which is at least ADDR_W+DATA_W wide, and masks the result to data_w bits.
package spi_rom_pkg;

    localparam int WORD_MAX_W = 64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    function automatic logic [WORD_MAX_W-1:0] word(
        input logic [WORD_MAX_W-1:0] addr,
        input int                    offset,
        input int                    data_w
    );
        logic [WORD_MAX_W-1:0] sum;
        logic [WORD_MAX_W-1:0] mask;
        sum  = addr + WORD_MAX_W'(offset);
        mask = (data_w >= WORD_MAX_W) ? '1
                                      : ((WORD_MAX_W'(1) << data_w) - WORD_MAX_W'(1));
        return sum & mask;
    endfunction

endpackage

// File: rtl/spi_rom_core.sv
// Combinational ROM lookup: data_o = (addr_i + OFFSET) mod 2**DATA_W.
module spi_rom_core
    import spi_rom_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int OFFSET = 1
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o
);

    assign data_o = DATA_W'(word(WORD_MAX_W'(addr_i), OFFSET, DATA_W));

endmodule

// File: rtl/spi_burst_rom.sv
// Burst reader for the constant ROM: captures a start address and length, then streams
// words through a one-entry ready/valid output register.
//
// state    | meaning
// ST_IDLE  | waiting for req with a non-zero burst_len
// ST_BURST | streaming words; stays here until the rd_last word has been accepted
module spi_burst_rom
    import spi_rom_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int LEN_W   = 8,
    parameter int OFFSET  = 1,
    parameter int WRAP_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] rom_word;
    logic              can_load;
    logic              at_top;

    spi_rom_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .OFFSET (OFFSET)
    ) u_core (
        .addr_i (addr_q),
        .data_o (rom_word)
    );

    assign can_load = !valid_q || rd_ready;
    assign at_top   = (addr_q == {ADDR_W{1'b1}});

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (req && (burst_len != '0)) begin
                    state_d = ST_BURST;
                    addr_d  = start_addr;
                    rem_d   = burst_len;
                end
            end
            ST_BURST: begin
                if (can_load) begin
                    if (rem_q != '0) begin
                        valid_d = 1'b1;
                        data_d  = rom_word;
                        // Without wrap the top address terminates the burst early.
                        last_d  = (rem_q == LEN_W'(1)) || ((WRAP_EN == 0) && at_top);
                        addr_d  = addr_q + ADDR_W'(1);
                        rem_d   = last_d ? '0 : (rem_q - LEN_W'(1));
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign rd_valid = valid_q;
    assign rd_data  = data_q;
    assign rd_last  = last_q;
    assign busy     = (state_q == ST_BURST);

endmodule

// File: tb/tb_spi_burst_rom.sv
// Bench for spi_burst_rom: three configurations (default, no-wrap, narrow) against a word-list model.
module tb_spi_burst_rom;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req_v;
    logic [7:0] start_addr;
    logic [7:0] burst_len;
    logic       rd_ready;

    logic       v0, v1, v2, l0, l1, l2, b0, b1, b2;
    logic [7:0] d0, d1;
    logic [3:0] d2;

    int tests_run = 0;
    int fails     = 0;

    int obs_data[$];
    int obs_last[$];
    int busy_cyc;
    int first_lat;
    int hold_err;

    always #5 clk = ~clk;

    spi_burst_rom u_def (
        .clk(clk), .rst(rst), .req(req_v[0]), .start_addr(start_addr), .burst_len(burst_len),
        .rd_ready(rd_ready), .rd_valid(v0), .rd_data(d0), .rd_last(l0), .busy(b0)
    );

    spi_burst_rom #(.WRAP_EN(0)) u_nowrap (
        .clk(clk), .rst(rst), .req(req_v[1]), .start_addr(start_addr), .burst_len(burst_len),
        .rd_ready(rd_ready), .rd_valid(v1), .rd_data(d1), .rd_last(l1), .busy(b1)
    );

    spi_burst_rom #(.DATA_W(4), .ADDR_W(6), .OFFSET(3)) u_small (
        .clk(clk), .rst(rst), .req(req_v[2]), .start_addr(start_addr[5:0]), .burst_len(burst_len),
        .rd_ready(rd_ready), .rd_valid(v2), .rd_data(d2), .rd_last(l2), .busy(b2)
    );

    function automatic bit get_valid(input int k);
        case (k) 0: return v0; 1: return v1; default: return v2; endcase
    endfunction
    function automatic bit get_last(input int k);
        case (k) 0: return l0; 1: return l1; default: return l2; endcase
    endfunction
    function automatic bit get_busy(input int k);
        case (k) 0: return b0; 1: return b1; default: return b2; endcase
    endfunction
    function automatic int get_data(input int k);
        case (k) 0: return int'(d0); 1: return int'(d1); default: return int'(d2); endcase
    endfunction

    // Reference: the burst is simply the list of addresses sa, sa+1, ... mapped through the content rule.
    function automatic int model_count(input int k, input int sa, input int len);
        int depth = (k == 2) ? 64 : 256;
        int a     = sa % depth;
        if (k == 1 && len > depth - a) return depth - a;
        return len;
    endfunction
    function automatic int model_word(input int k, input int sa, input int i);
        int depth = (k == 2) ? 64 : 256;
        int dmod  = (k == 2) ? 16 : 256;
        int off   = (k == 2) ? 3 : 1;
        return (((sa + i) % depth) + off) % dmod;
    endfunction

    // Issues one request on instance k and records every transferred word until busy falls.
    task automatic do_burst(input int k, input int sa, input int len, input logic [31:0] mask,
                            input int stall_pct, input int mid_cyc);
        int cyc;
        bit pv, pl;
        int pd;
        obs_data.delete();
        obs_last.delete();
        busy_cyc  = 0;
        first_lat = -1;
        hold_err  = 0;
        @(negedge clk);
        start_addr = 8'(sa);
        burst_len  = 8'(len);
        req_v[k]   = 1'b1;
        @(negedge clk);
        req_v[k] = 1'b0;
        cyc = 0; pv = 0; pd = 0; pl = 0;
        forever begin
            req_v[k] = (cyc == mid_cyc);
            if (cyc == mid_cyc) begin
                start_addr = 8'($urandom);
                burst_len  = 8'd5;
            end
            if (!get_busy(k)) break;
            if (cyc >= 400) begin
                tests_run++;
                fails++;
                $display("FAIL burst_timeout: busy still %0d after %0d cycles, required 0", get_busy(k), cyc);
                break;
            end
            busy_cyc++;
            if (pv && (!get_valid(k) || get_data(k) != pd || get_last(k) != pl)) hold_err++;
            if (get_valid(k) && first_lat < 0) first_lat = cyc;
            rd_ready = ((cyc < 32) ? mask[cyc] : 1'b1) && ($urandom_range(99) >= stall_pct);
            if (get_valid(k) && rd_ready) begin
                obs_data.push_back(get_data(k));
                obs_last.push_back(int'(get_last(k)));
            end
            pv = get_valid(k) && !rd_ready;
            pd = get_data(k);
            pl = get_last(k);
            @(negedge clk);
            cyc++;
        end
        req_v[k] = 1'b0;
        rd_ready = 1'b1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (get_valid(k) !== 1'b0) begin fails++; $display("FAIL reset_valid[%0d]: got %0b, required 0", k, get_valid(k)); end
            tests_run++;
            if (get_data(k) !== 0) begin fails++; $display("FAIL reset_data[%0d]: got %0h, required 0", k, get_data(k)); end
            tests_run++;
            if (get_last(k) !== 1'b0) begin fails++; $display("FAIL reset_last[%0d]: got %0b, required 0", k, get_last(k)); end
            tests_run++;
            if (get_busy(k) !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d]: got %0b, required 0", k, get_busy(k)); end
        end
    endtask

    task automatic test_basic();
        int exp_n;
        do_burst(0, 'h10, 4, '1, 0, -1);
        exp_n = model_count(0, 'h10, 4);
        tests_run++;
        if (obs_data.size() != exp_n) begin fails++; $display("FAIL basic_count: got %0d, required %0d", obs_data.size(), exp_n); end
        for (int i = 0; i < obs_data.size() && i < exp_n; i++) begin
            tests_run++;
            if (obs_data[i] != model_word(0, 'h10, i) || obs_last[i] != int'(i == exp_n - 1)) begin
                fails++;
                $display("FAIL basic_word[%0d]: got %0h last %0d, required %0h last %0d", i, obs_data[i], obs_last[i],
                         model_word(0, 'h10, i), int'(i == exp_n - 1));
            end
        end
        tests_run++;
        if (first_lat != 1) begin fails++; $display("FAIL basic_latency: got %0d, required 1", first_lat); end
        tests_run++;
        if (busy_cyc != 5) begin fails++; $display("FAIL basic_busy_cycles: got %0d, required 5", busy_cyc); end
    endtask

    task automatic test_wrap();
        int exp_n;
        for (int k = 0; k < 2; k++) begin
            do_burst(k, 'hFE, 4, '1, 0, -1);
            exp_n = model_count(k, 'hFE, 4);
            tests_run++;
            if (obs_data.size() != exp_n) begin fails++; $display("FAIL wrap_count[%0d]: got %0d, required %0d", k, obs_data.size(), exp_n); end
            for (int i = 0; i < obs_data.size() && i < exp_n; i++) begin
                tests_run++;
                if (obs_data[i] != model_word(k, 'hFE, i) || obs_last[i] != int'(i == exp_n - 1)) begin
                    fails++;
                    $display("FAIL wrap_word[%0d][%0d]: got %0h last %0d, required %0h last %0d", k, i, obs_data[i],
                             obs_last[i], model_word(k, 'hFE, i), int'(i == exp_n - 1));
                end
            end
            tests_run++;
            if (busy_cyc != exp_n + 1) begin fails++; $display("FAIL wrap_busy[%0d]: got %0d, required %0d", k, busy_cyc, exp_n + 1); end
        end
    endtask

    task automatic test_stall();
        int exp_w[3] = '{'h21, 'h22, 'h23};
        do_burst(0, 'h20, 3, ~32'h0000_000E, 0, -1);
        tests_run++;
        if (obs_data.size() != 3) begin fails++; $display("FAIL stall_count: got %0d, required 3", obs_data.size()); end
        for (int i = 0; i < obs_data.size() && i < 3; i++) begin
            tests_run++;
            if (obs_data[i] != exp_w[i] || obs_last[i] != int'(i == 2)) begin
                fails++;
                $display("FAIL stall_word[%0d]: got %0h last %0d, required %0h last %0d", i, obs_data[i], obs_last[i], exp_w[i], int'(i == 2));
            end
        end
        tests_run++;
        if (hold_err != 0) begin fails++; $display("FAIL stall_hold: got %0d changes while stalled, required 0", hold_err); end
        tests_run++;
        if (busy_cyc != 7) begin fails++; $display("FAIL stall_busy: got %0d, required 7", busy_cyc); end
    endtask

    task automatic test_ignore();
        @(negedge clk);
        start_addr = 8'h33;
        burst_len  = 8'd0;
        req_v[0]   = 1'b1;
        @(negedge clk);
        req_v[0] = 1'b0;
        tests_run++;
        if (b0 !== 1'b0 || v0 !== 1'b0) begin fails++; $display("FAIL zero_len: got busy %0b valid %0b, required 0 0", b0, v0); end
        @(negedge clk);
        tests_run++;
        if (b0 !== 1'b0 || v0 !== 1'b0) begin fails++; $display("FAIL zero_len_later: got busy %0b valid %0b, required 0 0", b0, v0); end
        do_burst(0, 'h50, 6, '1, 0, 2);
        tests_run++;
        if (obs_data.size() != 6) begin fails++; $display("FAIL midreq_count: got %0d, required 6", obs_data.size()); end
        for (int i = 0; i < obs_data.size() && i < 6; i++) begin
            tests_run++;
            if (obs_data[i] != model_word(0, 'h50, i)) begin
                fails++;
                $display("FAIL midreq_word[%0d]: got %0h, required %0h", i, obs_data[i], model_word(0, 'h50, i));
            end
        end
        tests_run++;
        if (busy_cyc != 7) begin fails++; $display("FAIL midreq_busy: got %0d, required 7", busy_cyc); end
    endtask

    task automatic test_req_on_last();
        do_burst(0, 'h70, 3, '1, 0, 3);
        tests_run++;
        if (obs_data.size() != 3) begin fails++; $display("FAIL lastreq_count: got %0d, required 3", obs_data.size()); end
        @(negedge clk);
        tests_run++;
        if (b0 !== 1'b0 || v0 !== 1'b0) begin fails++; $display("FAIL lastreq_idle: got busy %0b valid %0b, required 0 0", b0, v0); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start_addr = 8'h40;
        burst_len  = 8'd8;
        req_v[0]   = 1'b1;
        rd_ready   = 1'b1;
        @(negedge clk);
        req_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (v0 !== 1'b1 || d0 !== 8'h42) begin fails++; $display("FAIL rstmid_second: got valid %0b data %0h, required 1 42", v0, d0); end
        rst        = 1'b1;
        req_v[0]   = 1'b1;
        start_addr = 8'h00;
        burst_len  = 8'd1;
        @(negedge clk);
        tests_run++;
        if ({v0, d0, l0, b0} !== 11'd0) begin
            fails++;
            $display("FAIL rstmid_clear: got valid %0b data %0h last %0b busy %0b, required all 0", v0, d0, l0, b0);
        end
        rst      = 1'b0;
        req_v[0] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (b0 !== 1'b0 || v0 !== 1'b0) begin fails++; $display("FAIL rstmid_req_ignored: got busy %0b valid %0b, required 0 0", b0, v0); end
        do_burst(0, 'h00, 1, '1, 0, -1);
        tests_run++;
        if (obs_data.size() != 1) begin fails++; $display("FAIL rstmid_restart_count: got %0d, required 1", obs_data.size()); end
        else begin
            tests_run++;
            if (obs_data[0] != 'h01 || obs_last[0] != 1) begin
                fails++;
                $display("FAIL rstmid_restart_word: got %0h last %0d, required 01 last 1", obs_data[0], obs_last[0]);
            end
        end
    endtask

    task automatic test_small();
        int exp_w[3] = '{1, 2, 3};
        do_burst(2, 'h3E, 3, '1, 0, -1);
        tests_run++;
        if (obs_data.size() != 3) begin fails++; $display("FAIL small_count: got %0d, required 3", obs_data.size()); end
        for (int i = 0; i < obs_data.size() && i < 3; i++) begin
            tests_run++;
            if (obs_data[i] != exp_w[i] || obs_last[i] != int'(i == 2)) begin
                fails++;
                $display("FAIL small_word[%0d]: got %0h last %0d, required %0h last %0d", i, obs_data[i], obs_last[i], exp_w[i], int'(i == 2));
            end
        end
    endtask

    task automatic test_random();
        int k, sa, len, exp_n;
        for (int t = 0; t < 40; t++) begin
            k   = $urandom_range(2);
            len = $urandom_range(1, 24);
            sa  = ($urandom_range(2) == 0) ? (((k == 2) ? 64 : 256) - $urandom_range(1, 6)) : $urandom_range(255);
            do_burst(k, sa, len, '1, 35, -1);
            exp_n = model_count(k, sa, len);
            tests_run++;
            if (obs_data.size() != exp_n) begin
                fails++;
                $display("FAIL rand_count[%0d] k=%0d sa=%0h len=%0d: got %0d, required %0d", t, k, sa, len, obs_data.size(), exp_n);
            end
            for (int i = 0; i < obs_data.size() && i < exp_n; i++) begin
                tests_run++;
                if (obs_data[i] != model_word(k, sa, i) || obs_last[i] != int'(i == exp_n - 1)) begin
                    fails++;
                    $display("FAIL rand_word[%0d][%0d]: got %0h last %0d, required %0h last %0d", t, i, obs_data[i],
                             obs_last[i], model_word(k, sa, i), int'(i == exp_n - 1));
                end
            end
            tests_run++;
            if (hold_err != 0) begin fails++; $display("FAIL rand_hold[%0d]: got %0d changes while stalled, required 0", t, hold_err); end
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_v      = '0;
        start_addr = '0;
        burst_len  = '0;
        rd_ready   = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_basic();
        test_wrap();
        test_stall();
        test_ignore();
        test_req_on_last();
        test_reset_mid();
        test_small();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
